// File: rtl/index_decoder_pkg.sv
// Shared helpers for the index decoder: one-hot decode and range check.
package index_decoder_pkg;

    // Upper bound on any decoder width; helpers compute at this width and the
    // caller truncates to its own WIDTH.
    localparam int unsigned MAX_WIDTH = 1024;

    // 1 << idx, or all-zero when idx falls outside [0, width).
    function automatic logic [MAX_WIDTH-1:0] onehot(input int unsigned idx,
                                                   input int unsigned width);
        logic [MAX_WIDTH-1:0] res;
        res = '0;
        if (idx < width && idx < MAX_WIDTH) begin
            res = MAX_WIDTH'(1) << idx;
        end
        return res;
    endfunction

    function automatic logic in_range(input int unsigned idx,
                                      input int unsigned width);
        return (idx < width);
    endfunction

endpackage

// File: rtl/index_decoder_popcount.sv
// Combinational population count built as a recursive binary adder tree.
module popcount #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Split in halves until single bits remain, then sum the halves.
    if (WIDTH == 1) begin : g_leaf
        assign cnt_o = CNT_W'(bits_i);
    end else begin : g_node
        localparam int unsigned LO_W   = WIDTH / 2;
        localparam int unsigned HI_W   = WIDTH - LO_W;
        localparam int unsigned LO_CNT = $clog2(LO_W + 1);
        localparam int unsigned HI_CNT = $clog2(HI_W + 1);

        logic [LO_CNT-1:0] cnt_lo;
        logic [HI_CNT-1:0] cnt_hi;

        popcount #(.WIDTH(LO_W), .CNT_W(LO_CNT)) u_lo (
            .bits_i (bits_i[LO_W-1:0]),
            .cnt_o  (cnt_lo)
        );

        popcount #(.WIDTH(HI_W), .CNT_W(HI_CNT)) u_hi (
            .bits_i (bits_i[WIDTH-1:LO_W]),
            .cnt_o  (cnt_hi)
        );

        assign cnt_o = CNT_W'(cnt_lo) + CNT_W'(cnt_hi);
    end

endmodule

// File: rtl/index_decoder.sv
// Binary-to-one-hot event decoder with a registered output stage and a
// sticky pending-event vector retired by a per-bit clear mask.
// Optional duplicate-event detection: INDEX_DECODER_DUP_CHECK_EN.
module index_decoder
    import index_decoder_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned WIDTH_W = $clog2(WIDTH),
    parameter int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [WIDTH_W-1:0] id_bin,
    input  logic [WIDTH-1:0]   clr,
    output logic               od_valid,
    input  logic               od_ready,
    output logic [WIDTH-1:0]   od_onehot,
    output logic [WIDTH-1:0]   od_pend,
    output logic [CNT_W-1:0]   od_cnt,
    output logic               od_err,
    output logic               od_dup
);

    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   onehot_q, onehot_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               accept;
    logic               idx_ok;
    logic [WIDTH-1:0]   dec;
    logic [WIDTH-1:0]   set_mask;

    assign id_ready = !valid_q || od_ready;
    assign accept   = id_valid && id_ready;
    assign idx_ok   = in_range(32'(id_bin), WIDTH);
    assign dec      = WIDTH'(onehot(32'(id_bin), WIDTH));
    assign set_mask = accept ? dec : '0;

    // Output stage next state and pending update; set beats clear on a shared bit.
    always_comb begin
        valid_d  = valid_q;
        onehot_d = onehot_q;
        err_d    = 1'b0;
        if (accept) begin
            valid_d  = 1'b1;
            onehot_d = dec;
            err_d    = !idx_ok;
        end else if (od_ready) begin
            valid_d  = 1'b0;
        end
        pend_d = (pend_q & ~clr) | set_mask;
    end

    // Count is taken on the next pending state so it lines up with od_pend.
    popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_popcount (
        .bits_i (pend_d),
        .cnt_o  (cnt_d)
    );

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            onehot_q <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

`ifdef INDEX_DECODER_DUP_CHECK_EN
    logic dup_q;
    logic dup_hit;

    // A bit cleared in the same cycle was retired, so re-setting it is not a duplicate.
    assign dup_hit = accept && idx_ok && (|(pend_q & ~clr & dec));

    // Sticky duplicate flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= dup_q | dup_hit;
        end
    end

    assign od_dup = dup_q;
`else
    assign od_dup = 1'b0;
`endif

    assign od_valid  = valid_q;
    assign od_onehot = onehot_q;
    assign od_pend   = pend_q;
    assign od_cnt    = cnt_q;
    assign od_err    = err_q;

endmodule

// File: tb/tb_index_decoder.sv
// Self-checking bench: a 32-wide and a 20-wide decoder share one stimulus
// stream and are compared against a per-bit behavioural model.
module tb_index_decoder;

`ifdef INDEX_DECODER_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_bin;
    logic [31:0] clr;
    logic        od_ready;

    logic        a_id_ready, a_od_valid, a_od_err, a_od_dup;
    logic [31:0] a_od_onehot, a_od_pend;
    logic [5:0]  a_od_cnt;

    logic        b_id_ready, b_od_valid, b_od_err, b_od_dup;
    logic [19:0] b_od_onehot, b_od_pend;
    logic [4:0]  b_od_cnt;

    always #5 clk = ~clk;

    index_decoder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(a_id_ready),
        .id_bin(id_bin), .clr(clr), .od_valid(a_od_valid), .od_ready(od_ready),
        .od_onehot(a_od_onehot), .od_pend(a_od_pend), .od_cnt(a_od_cnt),
        .od_err(a_od_err), .od_dup(a_od_dup)
    );

    index_decoder #(.WIDTH(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(b_id_ready),
        .id_bin(id_bin), .clr(clr[19:0]), .od_valid(b_od_valid), .od_ready(od_ready),
        .od_onehot(b_od_onehot), .od_pend(b_od_pend), .od_cnt(b_od_cnt),
        .od_err(b_od_err), .od_dup(b_od_dup)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model, one slot per instance.
    int unsigned W [2] = '{32, 20};
    bit          m_pend  [2][32];
    bit          m_valid [2];
    logic [31:0] m_oh    [2];
    bit          m_err   [2];
    bit          m_dup   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
            m_valid[k] = 1'b0;
            m_oh[k]    = '0;
            m_err[k]   = 1'b0;
            m_dup[k]   = 1'b0;
        end
    endtask

    function automatic logic [31:0] pend_word(input int k);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) if (m_pend[k][i]) w = w | (32'd1 << i);
        return w;
    endfunction

    function automatic int pend_count(input int k);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[k][i]);
        return n;
    endfunction

    task automatic model_step(input bit v, input int b, input logic [31:0] c, input bit r);
        for (int k = 0; k < 2; k++) begin
            bit acc;
            bit inr;
            acc = v && (!m_valid[k] || r);
            inr = (b < int'(W[k]));
            for (int i = 0; i < int'(W[k]); i++) begin
                bit nb;
                nb = m_pend[k][i] && !c[i];
                if (acc && inr && i == b) begin
                    if (nb) m_dup[k] = 1'b1;
                    nb = 1'b1;
                end
                m_pend[k][i] = nb;
            end
            if (acc) begin
                m_valid[k] = 1'b1;
                m_oh[k]    = inr ? (32'd1 << b) : 32'd0;
                m_err[k]   = !inr;
            end else begin
                if (r) m_valid[k] = 1'b0;
                m_err[k] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid32",  {31'd0, a_od_valid}, {31'd0, m_valid[0]});
        chk("onehot32", a_od_onehot, m_oh[0]);
        chk("pend32",   a_od_pend, pend_word(0));
        chk("cnt32",    {26'd0, a_od_cnt}, 32'(pend_count(0)));
        chk("err32",    {31'd0, a_od_err}, {31'd0, m_err[0]});
        chk("dup32",    {31'd0, a_od_dup}, {31'd0, DUP_EN & m_dup[0]});
        chk("valid20",  {31'd0, b_od_valid}, {31'd0, m_valid[1]});
        chk("onehot20", {12'd0, b_od_onehot}, m_oh[1]);
        chk("pend20",   {12'd0, b_od_pend}, pend_word(1));
        chk("cnt20",    {27'd0, b_od_cnt}, 32'(pend_count(1)));
        chk("err20",    {31'd0, b_od_err}, {31'd0, m_err[1]});
        chk("dup20",    {31'd0, b_od_dup}, {31'd0, DUP_EN & m_dup[1]});
    endtask

    // One clock: drive, check ready, advance model, clock, check registered outputs.
    task automatic cyc(input bit v, input int b, input logic [31:0] c, input bit r);
        id_valid = v;
        id_bin   = 5'(b);
        clr      = c;
        od_ready = r;
        #1;
        chk("ready32", {31'd0, a_id_ready}, {31'd0, (!m_valid[0] || r)});
        chk("ready20", {31'd0, b_id_ready}, {31'd0, (!m_valid[1] || r)});
        model_step(v, b, c, r);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_bin = '0; clr = '0; od_ready = 1'b1;
        model_reset();
        #12;
        check_outputs();
        chk("reset_ready", {31'd0, a_id_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single accept of index 5.
        cyc(1, 5, 32'h0, 1);
        chk("t1_onehot", a_od_onehot, 32'h20);
        chk("t1_pend",   a_od_pend, 32'h20);
        chk("t1_cnt",    {26'd0, a_od_cnt}, 32'd1);

        // Back-pressure holds the output word.
        cyc(1, 3, 32'h0, 1);
        cyc(1, 7, 32'h0, 0);
        chk("t2_hold", a_od_onehot, 32'h08);
        id_valid = 1'b1; id_bin = 5'd7; od_ready = 1'b0; #1;
        chk("t2_notready", {31'd0, a_id_ready}, 32'd0);
        cyc(1, 7, 32'h0, 1);
        chk("t2_onehot", a_od_onehot, 32'h80);

        // Clear with simultaneous set on a cleared bit.
        cyc(0, 0, 32'hFFFF_FFFF, 1);
        for (int i = 0; i < 4; i++) cyc(1, i, 32'h0, 1);
        chk("t3_pre", a_od_pend, 32'h0F);
        cyc(1, 1, 32'h3, 1);
        chk("t3_pend", a_od_pend, 32'h0E);
        chk("t3_cnt",  {26'd0, a_od_cnt}, 32'd3);

        // Out-of-range index on the 20-wide instance.
        cyc(1, 25, 32'h0, 1);
        chk("t4_err",    {31'd0, b_od_err}, 32'd1);
        chk("t4_onehot", {12'd0, b_od_onehot}, 32'd0);
        chk("t4_pend",   {12'd0, b_od_pend}, 32'h0E);
        cyc(0, 0, 32'h0, 1);
        chk("t4_errdrop", {31'd0, b_od_err}, 32'd0);

        // Duplicate detection on index 9.
        cyc(1, 9, 32'h0, 1);
        chk("t5_dup_first", {31'd0, a_od_dup}, 32'd0);
        cyc(1, 9, 32'h0, 1);
        cyc(0, 0, 32'h0, 1);
        chk("t5_dup", {31'd0, a_od_dup}, {31'd0, DUP_EN});

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                $urandom & $urandom & $urandom, ($urandom_range(0, 3) != 0));
        end

        // Fill every bit, then reset mid-stream.
        for (int i = 0; i < 32; i++) cyc(1, i, 32'h0, 1);
        chk("t6_full", a_od_pend, 32'hFFFF_FFFF);
        id_valid = 1'b1; id_bin = 5'd4; od_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_pend",  a_od_pend, 32'h0);
        chk("t6_cnt",   {26'd0, a_od_cnt}, 32'd0);
        chk("t6_valid", {31'd0, a_od_valid}, 32'd0);
        chk("t6_ready", {31'd0, a_id_ready}, 32'd1);
        check_outputs();
        id_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 12, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
